// File: rtl/dafir.sv
// dafir: four-tap bit-serial distributed-arithmetic FIR filter (8-bit signed in, 17-bit signed out).
// Define DAFIR_VALID_EN to add the y_valid strobe that marks each opy update.
module dafir #(
    parameter logic signed [7:0] H0 = 8'sd1,
    parameter logic signed [7:0] H1 = 8'sd2,
    parameter logic signed [7:0] H2 = 8'sd3,
    parameter logic signed [7:0] H3 = 8'sd4
) (
    input  logic        clk_bit,
    input  logic        rst_n,
    input  logic [7:0]  xnp1,
`ifdef DAFIR_VALID_EN
    output logic        y_valid,
`endif
    output logic [16:0] opy
);

    localparam int DATA_W = 8;
    localparam int LUT_W  = 10;
    localparam int ACC_W  = 18;

    logic [DATA_W-1:0]       t0_q, t1_q, t2_q, t3_q;
    logic [2:0]              bitcnt_q, bitcnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [16:0]             opy_q, opy_d;
    logic [3:0]              addr;
    logic signed [LUT_W-1:0] lut_v;
    logic signed [ACC_W-1:0] term;
    logic                    frame_end;

    // Coefficient-sum table: entry a is the sum of Hk for every set bit k of a.
    function automatic logic signed [LUT_W-1:0] lut_sum(input logic [3:0] a);
        logic signed [LUT_W-1:0] s;
        s = '0;
        if (a[0]) s = s + {{(LUT_W-8){H0[7]}}, H0};
        if (a[1]) s = s + {{(LUT_W-8){H1[7]}}, H1};
        if (a[2]) s = s + {{(LUT_W-8){H2[7]}}, H2};
        if (a[3]) s = s + {{(LUT_W-8){H3[7]}}, H3};
        return s;
    endfunction

    always_comb begin
        frame_end = (bitcnt_q == 3'd7);
        bitcnt_d  = bitcnt_q + 3'd1;
        addr      = {t3_q[bitcnt_q], t2_q[bitcnt_q], t1_q[bitcnt_q], t0_q[bitcnt_q]};
        lut_v     = lut_sum(addr);
        term      = {{(ACC_W-LUT_W){lut_v[LUT_W-1]}}, lut_v} << bitcnt_q;
        // Bit 7 carries the two's-complement sign weight, hence the subtraction.
        if (bitcnt_q == 3'd0) begin
            acc_d = term;
        end else if (frame_end) begin
            acc_d = acc_q - term;
        end else begin
            acc_d = acc_q + term;
        end
        opy_d = frame_end ? acc_d[16:0] : opy_q;
    end

    always_ff @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q <= '0;
            acc_q    <= '0;
            opy_q    <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            t2_q     <= '0;
            t3_q     <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            acc_q    <= acc_d;
            opy_q    <= opy_d;
            // Result above used the pre-shift taps; the new sample enters on the same edge.
            if (frame_end) begin
                t3_q <= t2_q;
                t2_q <= t1_q;
                t1_q <= t0_q;
                t0_q <= xnp1;
            end
        end
    end

    assign opy = opy_q;

`ifdef DAFIR_VALID_EN
    logic valid_q;

    always_ff @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= frame_end;
        end
    end

    assign y_valid = valid_q;
`endif

endmodule

// File: tb/tb_dafir.sv
// tb_dafir: randomized and directed check of dafir against a tap-history convolution model.
// Build with DAFIR_VALID_EN defined to also check the y_valid strobe.
module tb_dafir;

    localparam logic signed [7:0] C0 = 8'sd1;
    localparam logic signed [7:0] C1 = 8'sd2;
    localparam logic signed [7:0] C2 = 8'sd3;
    localparam logic signed [7:0] C3 = 8'sd4;

    logic        clk_bit = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  xnp1    = '0;
    logic [16:0] opy;
`ifdef DAFIR_VALID_EN
    logic        y_valid;
`endif

    int checks = 0;
    int errors = 0;

    dafir #(.H0(C0), .H1(C1), .H2(C2), .H3(C3)) dut (
        .clk_bit (clk_bit),
        .rst_n   (rst_n),
        .xnp1    (xnp1),
`ifdef DAFIR_VALID_EN
        .y_valid (y_valid),
`endif
        .opy     (opy)
    );

    always #5 clk_bit = ~clk_bit;

    // Reference: every 8th edge since reset, y = sum Hk*x[n-k]; then the new sample is pushed.
    int   m_edges;
    int   m_hist [4];
    int   m_y;
    logic m_vld;

    always @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            m_edges <= 0;
            m_hist  <= '{0, 0, 0, 0};
            m_y     <= 0;
            m_vld   <= 1'b0;
        end else begin
            m_edges <= m_edges + 1;
            if (m_edges % 8 == 7) begin
                m_y <= int'(C0) * m_hist[0] + int'(C1) * m_hist[1]
                     + int'(C2) * m_hist[2] + int'(C3) * m_hist[3];
                m_hist[0] <= int'($signed(xnp1));
                m_hist[1] <= m_hist[0];
                m_hist[2] <= m_hist[1];
                m_hist[3] <= m_hist[2];
                m_vld <= 1'b1;
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk_bit) begin
        checks++;
        if (int'($signed(opy)) != m_y) begin
            errors++;
            $display("FAIL opy_model t=%0t got=%0d want=%0d", $time, $signed(opy), m_y);
        end
`ifdef DAFIR_VALID_EN
        checks++;
        if (y_valid !== m_vld) begin
            errors++;
            $display("FAIL y_valid t=%0t got=%b want=%b", $time, y_valid, m_vld);
        end
`endif
    end

    task automatic check_lit(input string name, input int want);
        checks++;
        if (int'($signed(opy)) != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, $signed(opy), want);
        end
    endtask

    // One frame: junk on the ignored edges, the sample on the capture edge.
    task automatic send(input int x);
        repeat (7) begin
            xnp1 = 8'($urandom);
            @(negedge clk_bit);
        end
        xnp1 = 8'(x);
        @(negedge clk_bit);
    endtask

    int seq_x [6]  = '{-6, 9, 0, 2, 11, 0};
    int seq_y [5]  = '{-6, -3, 0, 5, 51};
    int imp_y [5]  = '{1, 2, 3, 4, 0};

    initial begin
        repeat (3) @(negedge clk_bit);
        check_lit("reset_opy", 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            xnp1 = 8'd0;
            repeat (8) @(negedge clk_bit);
            check_lit("zero_input", 0);
        end

        for (int i = 0; i < 6; i++) begin
            send(seq_x[i]);
            if (i > 0) check_lit("seq", seq_y[i-1]);
        end

        send(0); send(0); send(0); send(0);
        send(1);
        for (int i = 0; i < 5; i++) begin
            send(0);
            check_lit("impulse", imp_y[i]);
        end

        for (int i = 0; i < 5; i++) send(-128);
        check_lit("neg_extreme", -1280);
        for (int i = 0; i < 5; i++) send(127);
        check_lit("pos_extreme", 1270);

        // Reset mid-frame at bitcnt = 4.
        repeat (4) @(posedge clk_bit);
        #1 rst_n = 1'b0;
        #1 check_lit("async_reset", 0);
        @(negedge clk_bit);
        rst_n = 1'b1;
        send(5);
        check_lit("post_reset_first", 0);
        send(0);
        check_lit("post_reset_second", 5);

        for (int i = 0; i < 300; i++) send(int'($signed(8'($urandom))));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
